// File: rtl/estacionamiento_sensor_gen.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : estacionamiento_sensor_gen
// Brief  : Drives active-low btnA/btnB through the 4-phase parking sensor
//          pattern for one command per handshake. `define SHADOW_COUNT_EN
//          adds a shadow occupancy counter (exp_count/exp_full).
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
module estacionamiento_sensor_gen #(
   parameter int STEP_CYCLES = 1,
   parameter int MAX_CARS    = 7
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          cmd_valid,
   input  logic [1:0]                    cmd_type,
   output logic                          cmd_ready,
   input  logic                          abort,
   output logic                          btnA,
   output logic                          btnB,
   output logic                          busy,
   output logic                          done
`ifdef SHADOW_COUNT_EN
   ,
   output logic [$clog2(MAX_CARS+1)-1:0] exp_count,
   output logic                          exp_full
`endif
);

   localparam int SW = $clog2(STEP_CYCLES + 1);
   localparam logic [SW-1:0] C_STEP_LAST = SW'(STEP_CYCLES - 1);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_PH0  = 3'd1;
   localparam logic [2:0] S_PH1  = 3'd2;
   localparam logic [2:0] S_PH2  = 3'd3;
   localparam logic [2:0] S_PH3  = 3'd4;

   localparam logic [1:0] CMD_CAR_IN   = 2'b00;
   localparam logic [1:0] CMD_CAR_OUT  = 2'b01;
   localparam logic [1:0] CMD_PERSON_A = 2'b10;
   localparam logic [1:0] CMD_PERSON_B = 2'b11;

   logic [2:0]    state_q, state_d;
   logic [SW-1:0] step_q,  step_d;
   logic [1:0]    type_q,  type_d;
   logic [1:0]    btn_q,   btn_d;   // {btnA, btnB}
   logic          done_q,  done_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         step_q  <= '0;
         type_q  <= CMD_CAR_IN;
         btn_q   <= 2'b11;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         type_q  <= type_d;
         btn_q   <= btn_d;
         done_q  <= done_d;
      end
   end

   // abort takes priority over both phase advance and a same-cycle accept
   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      type_d  = type_q;
      case (state_q)
         S_IDLE: begin
            if (cmd_valid && !abort) begin
               state_d = S_PH0;
               step_d  = C_STEP_LAST;
               type_d  = cmd_type;
            end
         end
         S_PH0, S_PH1, S_PH2, S_PH3: begin
            if (abort) begin
               state_d = S_IDLE;
               step_d  = '0;
            end else if (step_q == '0) begin
               state_d = (state_q == S_PH3) ? S_IDLE : 3'(state_q + 3'd1);
               step_d  = (state_q == S_PH3) ? '0 : C_STEP_LAST;
            end else begin
               step_d  = step_q - SW'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
            step_d  = '0;
         end
      endcase
   end

   // Outputs are computed from the next state so the registered lines align with it
   always_comb begin
      btn_d  = 2'b11;
      done_d = (state_d == S_PH3) && (step_d == '0);
      case (type_d)
         CMD_CAR_IN: begin
            case (state_d)
               S_PH0:   btn_d = 2'b01;
               S_PH1:   btn_d = 2'b00;
               S_PH2:   btn_d = 2'b10;
               default: btn_d = 2'b11;
            endcase
         end
         CMD_CAR_OUT: begin
            case (state_d)
               S_PH0:   btn_d = 2'b10;
               S_PH1:   btn_d = 2'b00;
               S_PH2:   btn_d = 2'b01;
               default: btn_d = 2'b11;
            endcase
         end
         CMD_PERSON_A: btn_d = (state_d == S_PH0) ? 2'b01 : 2'b11;
         CMD_PERSON_B: btn_d = (state_d == S_PH0) ? 2'b10 : 2'b11;
         default:      btn_d = 2'b11;
      endcase
   end

   assign btnA      = btn_q[1];
   assign btnB      = btn_q[0];
   assign done      = done_q;
   assign busy      = (state_q != S_IDLE);
   assign cmd_ready = (state_q == S_IDLE);

`ifdef SHADOW_COUNT_EN
   localparam int CW = $clog2(MAX_CARS + 1);
   localparam logic [CW-1:0] C_MAX = CW'(MAX_CARS);

   logic [CW-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (done_q) begin
         if (type_q == CMD_CAR_IN && count_q != C_MAX)
            count_d = count_q + CW'(1);
         else if (type_q == CMD_CAR_OUT && count_q != '0)
            count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) count_q <= '0;
      else       count_q <= count_d;
   end

   assign exp_count = count_q;
   assign exp_full  = (count_q == C_MAX);
`endif

endmodule
`default_nettype wire

// File: tb/tb_estacionamiento_sensor_gen.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : tb_estacionamiento_sensor_gen
// Brief  : Directed self-checking bench, one instance with STEP_CYCLES=1 and one
//          with STEP_CYCLES=3. Shadow-count checks follow SHADOW_COUNT_EN.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_estacionamiento_sensor_gen;

   logic       clk = 1'b0;
   logic       reset;
   logic       v1, ab1, v3, ab3;
   logic [1:0] t1, t3;
   logic       rdy1, a1, b1, busy1, done1;
   logic       rdy3, a3, b3, busy3, done3;
`ifdef SHADOW_COUNT_EN
   logic [2:0] cnt1, cnt3;
   logic       full1, full3;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   estacionamiento_sensor_gen #(.STEP_CYCLES(1), .MAX_CARS(7)) u1 (
      .clk(clk), .reset(reset), .cmd_valid(v1), .cmd_type(t1), .cmd_ready(rdy1),
      .abort(ab1), .btnA(a1), .btnB(b1), .busy(busy1), .done(done1)
`ifdef SHADOW_COUNT_EN
      , .exp_count(cnt1), .exp_full(full1)
`endif
   );

   estacionamiento_sensor_gen #(.STEP_CYCLES(3), .MAX_CARS(7)) u3 (
      .clk(clk), .reset(reset), .cmd_valid(v3), .cmd_type(t3), .cmd_ready(rdy3),
      .abort(ab3), .btnA(a3), .btnB(b3), .busy(busy3), .done(done3)
`ifdef SHADOW_COUNT_EN
      , .exp_count(cnt3), .exp_full(full3)
`endif
   );

   // Stimulus only: reset pulse, leaves time at posedge+1
   task automatic do_reset();
      v1 = 0; ab1 = 0; t1 = 0; v3 = 0; ab3 = 0; t3 = 0;
      reset = 1;
      @(posedge clk); #1;
      reset = 0;
   endtask

   // Stimulus only: one full STEP_CYCLES=1 sequence, returns in the first idle cycle
   task automatic run1(input logic [1:0] ty);
      v1 = 1; t1 = ty;
      @(posedge clk); #1;
      v1 = 0;
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if ({a1, b1} !== 2'b11) begin errors++; $display("FAIL rst_btn got %b exp 11", {a1, b1}); end
      checks++; if (rdy1 !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", rdy1); end
      checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy1); end
      checks++; if (done1 !== 1'b0) begin errors++; $display("FAIL rst_done got %b exp 0", done1); end
`ifdef SHADOW_COUNT_EN
      checks++; if (cnt1 !== 3'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", cnt1); end
`endif
   endtask

   task automatic test_car_in();
      logic [1:0] pat [4] = '{2'b01, 2'b00, 2'b10, 2'b11};
      v1 = 1; t1 = 2'b00;
      checks++; if (rdy1 !== 1'b1) begin errors++; $display("FAIL ci_ready0 got %b exp 1", rdy1); end
      @(posedge clk); #1;
      v1 = 0;
      for (int k = 0; k < 4; k++) begin
         checks++; if ({a1, b1} !== pat[k]) begin errors++; $display("FAIL ci_btn cyc=%0d got %b exp %b", k + 1, {a1, b1}, pat[k]); end
         checks++; if (done1 !== (k == 3)) begin errors++; $display("FAIL ci_done cyc=%0d got %b exp %b", k + 1, done1, (k == 3)); end
         checks++; if ({rdy1, busy1} !== 2'b01) begin errors++; $display("FAIL ci_rdybusy cyc=%0d got %b exp 01", k + 1, {rdy1, busy1}); end
         @(posedge clk); #1;
      end
      checks++; if ({rdy1, busy1, done1, a1, b1} !== 5'b10011) begin errors++; $display("FAIL ci_idle got %b exp 10011", {rdy1, busy1, done1, a1, b1}); end
`ifdef SHADOW_COUNT_EN
      checks++; if (cnt1 !== 3'd1) begin errors++; $display("FAIL ci_count got %0d exp 1", cnt1); end
`endif
   endtask

   task automatic test_car_out_person_a();
      logic [1:0] pat [2][4] = '{'{2'b10, 2'b00, 2'b01, 2'b11}, '{2'b01, 2'b11, 2'b11, 2'b11}};
      logic [1:0] ty  [2]    = '{2'b01, 2'b10};
      do_reset();
      for (int c = 0; c < 2; c++) begin
         v1 = 1; t1 = ty[c];
         @(posedge clk); #1;
         v1 = 0;
         for (int k = 0; k < 4; k++) begin
            checks++; if ({a1, b1} !== pat[c][k]) begin errors++; $display("FAIL copa_btn cmd=%0d cyc=%0d got %b exp %b", c, k + 1, {a1, b1}, pat[c][k]); end
            checks++; if (done1 !== (k == 3)) begin errors++; $display("FAIL copa_done cmd=%0d cyc=%0d got %b", c, k + 1, done1); end
            @(posedge clk); #1;
         end
         checks++; if (rdy1 !== 1'b1) begin errors++; $display("FAIL copa_ready cmd=%0d got %b exp 1", c, rdy1); end
`ifdef SHADOW_COUNT_EN
         checks++; if (cnt1 !== 3'd0) begin errors++; $display("FAIL copa_count cmd=%0d got %0d exp 0", c, cnt1); end
`endif
      end
   endtask

   task automatic test_saturation();
      for (int i = 1; i <= 8; i++) begin
         run1(2'b00);
`ifdef SHADOW_COUNT_EN
         checks++; if (cnt1 !== 3'((i > 7) ? 7 : i)) begin errors++; $display("FAIL sat_count n=%0d got %0d exp %0d", i, cnt1, (i > 7) ? 7 : i); end
         checks++; if (full1 !== (i >= 7)) begin errors++; $display("FAIL sat_full n=%0d got %b exp %b", i, full1, (i >= 7)); end
`else
         checks++; if (rdy1 !== 1'b1) begin errors++; $display("FAIL sat_ready n=%0d got %b exp 1", i, rdy1); end
`endif
      end
      run1(2'b01);
`ifdef SHADOW_COUNT_EN
      checks++; if (cnt1 !== 3'd6) begin errors++; $display("FAIL sat_dec got %0d exp 6", cnt1); end
      checks++; if (full1 !== 1'b0) begin errors++; $display("FAIL sat_full_clr got %b exp 0", full1); end
`endif
   endtask

   task automatic test_abort_reset();
      v1 = 1; t1 = 2'b00;
      @(posedge clk); #1;
      v1 = 0;
      @(posedge clk); #1;
      checks++; if ({a1, b1} !== 2'b00) begin errors++; $display("FAIL ab_ph1 got %b exp 00", {a1, b1}); end
      ab1 = 1;
      @(posedge clk); #1;
      ab1 = 0;
      checks++; if ({rdy1, busy1, done1, a1, b1} !== 5'b10011) begin errors++; $display("FAIL ab_idle got %b exp 10011", {rdy1, busy1, done1, a1, b1}); end
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         checks++; if (done1 !== 1'b0) begin errors++; $display("FAIL ab_nodone k=%0d got %b exp 0", k, done1); end
      end
`ifdef SHADOW_COUNT_EN
      checks++; if (cnt1 !== 3'd6) begin errors++; $display("FAIL ab_count got %0d exp 6", cnt1); end
`endif
      // abort in the same cycle as a would-be accept
      v1 = 1; ab1 = 1;
      @(posedge clk); #1;
      v1 = 0; ab1 = 0;
      checks++; if ({busy1, a1, b1} !== 3'b011) begin errors++; $display("FAIL ab_accept got %b exp 011", {busy1, a1, b1}); end
      v1 = 1; t1 = 2'b00;
      @(posedge clk); #1;
      v1 = 0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if ({a1, b1} !== 2'b10) begin errors++; $display("FAIL rs_ph2 got %b exp 10", {a1, b1}); end
      #2 reset = 1;
      #1;
      checks++; if ({rdy1, busy1, done1, a1, b1} !== 5'b10011) begin errors++; $display("FAIL rs_async got %b exp 10011", {rdy1, busy1, done1, a1, b1}); end
      @(posedge clk); #1;
      reset = 0;
   endtask

   task automatic test_step3();
      v3 = 1; t3 = 2'b11;
      @(posedge clk); #1;
      for (int k = 1; k <= 12; k++) begin
         checks++; if ({a3, b3} !== ((k <= 3) ? 2'b10 : 2'b11)) begin errors++; $display("FAIL s3_btn cyc=%0d got %b", k, {a3, b3}); end
         checks++; if (done3 !== (k == 12)) begin errors++; $display("FAIL s3_done cyc=%0d got %b exp %b", k, done3, (k == 12)); end
         checks++; if (rdy3 !== 1'b0) begin errors++; $display("FAIL s3_ready cyc=%0d got %b exp 0", k, rdy3); end
         if (k == 6) t3 = 2'b00;
         @(posedge clk); #1;
      end
      checks++; if ({rdy3, busy3, a3, b3} !== 4'b1011) begin errors++; $display("FAIL s3_idle got %b exp 1011", {rdy3, busy3, a3, b3}); end
      @(posedge clk); #1;
      v3 = 0;
      checks++; if ({busy3, a3, b3} !== 3'b101) begin errors++; $display("FAIL s3_reaccept got %b exp 101", {busy3, a3, b3}); end
      repeat (12) @(posedge clk);
      #1;
      checks++; if (busy3 !== 1'b0) begin errors++; $display("FAIL s3_end got %b exp 0", busy3); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      @(posedge clk); #1;
      test_reset();
      test_car_in();
      test_car_out_person_a();
      test_saturation();
      test_abort_reset();
      test_step3();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
